// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes, opcodes and skid states shared by imm_gen_pipe and imm_extract
package imm_gen_pkg;
  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_SH = 3'd6;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational RV32I/RV64I immediate decode, sign-extended to XLEN (32 or 64)
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illeg
);
  logic [31:0] v;
  logic        shift;
  logic        sh_hi;
  assign shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
  assign sh_hi = (XLEN == 64) ? inst[25] : 1'b0;
  // Build a 32-bit signed immediate per format; shift amounts stay positive so the final widening is uniform
  always_comb begin
    v = '0;
    fmt = FMT_R;
    illeg = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt = FMT_I;
        v = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_OP_IMM: begin
        fmt = shift ? FMT_SH : FMT_I;
        v = shift ? {26'b0, sh_hi, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        v = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_OP: ;
      default: illeg = 1'b1;
    endcase
  end
  assign imm = XLEN'(signed'(v));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with valid/ready and 2-entry skid; IMM_GEN_FLUSH_EN adds a flush port
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef IMM_GEN_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illeg,
  output logic [TAG_W-1:0] out_tag
);
  localparam int W = XLEN + 4 + TAG_W;
  logic [1:0]      state, next;
  logic [W-1:0]    dec, out_r, skid_r;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illeg;
  logic            accept, pop;
  imm_extract #(.XLEN(XLEN)) u_extract (.inst(in_inst), .imm(imm), .fmt(fmt), .illeg(illeg));
  assign dec = {imm, fmt, illeg, in_tag};
  assign in_ready = state != ST_FULL;
  assign out_valid = state != ST_EMPTY;
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_imm, out_fmt, out_illeg, out_tag} = out_r;
  // Skid occupancy: the output register is the head, skid_r holds the second entry
  always_comb begin
    next = state;
    case (state)
      ST_EMPTY: next = accept ? ST_ONE : ST_EMPTY;
      ST_ONE:   next = (accept && !pop) ? ST_FULL : (!accept && pop) ? ST_EMPTY : ST_ONE;
      default:  next = pop ? ST_ONE : ST_FULL;
    endcase
  end
  // Load the head from the decoder when it is free or draining, otherwise from the skid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      out_r <= '0;
      skid_r <= '0;
    end
`ifdef IMM_GEN_FLUSH_EN
    else if (flush) begin
      state <= ST_EMPTY;
    end
`endif
    else begin
      state <= next;
      if (accept && (state == ST_EMPTY || pop)) out_r <= dec;
      else if (state == ST_FULL && pop) out_r <= skid_r;
      if (accept && state == ST_ONE && !pop) skid_r <= dec;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against a queue-based reference model
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illeg;
    logic [7:0]  tag;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [7:0]  in_tag = '0;
  logic        in_ready, out_valid, out_illeg;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  out_tag;
  logic        v64 = 1'b0, rdy64 = 1'b1, ir64, ov64, ill64;
  logic [31:0] i64 = '0;
  logic [7:0]  t64 = '0, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  int          checks = 0, errors = 0;
  exp_t        q[$];
  logic [7:0]  tg = 8'd0;
  logic [6:0]  opcs [0:10] = '{OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH,
                               OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, 7'h7F};

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef IMM_GEN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illeg(out_illeg), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n),
`ifdef IMM_GEN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(v64), .in_ready(ir64), .in_inst(i64), .in_tag(t64),
    .out_valid(ov64), .out_ready(rdy64), .out_imm(imm64), .out_fmt(fmt64),
    .out_illeg(ill64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", n, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] inst, input logic [7:0] tag, input int xlen);
    longint s, u, imm;
    exp_t e;
    s = longint'(signed'(inst));
    u = inst;
    imm = 0;
    e.fmt = FMT_R;
    e.illeg = 1'b0;
    e.tag = tag;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin e.fmt = FMT_I; imm = s >>> 20; end
      OPC_OP_IMM:
        if (inst[13:12] == 2'b01) begin e.fmt = FMT_SH; imm = (u >> 20) & (xlen == 64 ? 63 : 31); end
        else begin e.fmt = FMT_I; imm = s >>> 20; end
      OPC_STORE: begin e.fmt = FMT_S; imm = ((s >>> 25) <<< 5) | ((u >> 7) & 31); end
      OPC_BRANCH: begin
        e.fmt = FMT_B;
        imm = ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      end
      OPC_LUI, OPC_AUIPC: begin e.fmt = FMT_U; imm = (s >>> 12) * 4096; end
      OPC_JAL: begin
        e.fmt = FMT_J;
        imm = ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      end
      OPC_OP: imm = 0;
      default: e.illeg = 1'b1;
    endcase
    e.imm = (xlen == 64) ? imm : (imm & 64'hFFFF_FFFF);
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] i, input logic [7:0] t, input logic r);
    exp_t e;
    bit acc, pp;
    in_valid = v; in_inst = i; in_tag = t; out_ready = r;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    acc = v && q.size() < 2;
    pp = r && q.size() != 0;
    if (pp) begin
      e = q.pop_front();
      chk("q_imm", out_imm, e.imm);
      chk("q_fmt", out_fmt, e.fmt);
      chk("q_illeg", out_illeg, e.illeg);
      chk("q_tag", out_tag, e.tag);
    end
    if (acc) q.push_back(model(i, t, 32));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dir(input string n, input logic [31:0] i, input logic [31:0] ei, input logic [2:0] ef,
                     input logic el);
    tg++;
    step(1'b1, i, tg, 1'b1);
    chk({n, "_valid"}, out_valid, 1'b1);
    chk({n, "_imm"}, out_imm, ei);
    chk({n, "_fmt"}, out_fmt, ef);
    chk({n, "_illeg"}, out_illeg, el);
    chk({n, "_tag"}, out_tag, tg);
  endtask

  task automatic dir64(input string n, input logic [31:0] i, input logic [63:0] ei, input logic [2:0] ef);
    exp_t e;
    e = model(i, 8'h40, 64);
    v64 = 1'b1; i64 = i; t64 = 8'h40;
    @(posedge clk);
    @(negedge clk);
    v64 = 1'b0;
    chk({n, "_valid"}, ov64, 1'b1);
    chk({n, "_imm"}, imm64, ei);
    chk({n, "_model"}, imm64, e.imm);
    chk({n, "_fmt"}, fmt64, ef);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_fmt", out_fmt, FMT_R);
    chk("rst_out_illeg", out_illeg, 1'b0);
    chk("rst_out_tag", out_tag, 8'h0);
    rst_n = 1'b1;
    dir64("lui64", 32'h800000B7, 64'hFFFF_FFFF_8000_0000, FMT_U);
    dir64("slli64", 32'h02011093, 64'h20, FMT_SH);
    @(negedge clk);
    dir("addi", 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    dir("sw", 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
    dir("beq", 32'hFE000CE3, 32'hFFFFFFF8, FMT_B, 1'b0);
    dir("lui", 32'h123452B7, 32'h12345000, FMT_U, 1'b0);
    dir("jal", 32'h001000EF, 32'h00000800, FMT_J, 1'b0);
    dir("slli", 32'h00311093, 32'h00000003, FMT_SH, 1'b0);
    dir("srai", 32'h4031D093, 32'h00000003, FMT_SH, 1'b0);
    dir("add", 32'h002081B3, 32'h0, FMT_R, 1'b0);
    dir("illegal", 32'h0000007F, 32'h0, FMT_R, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    step(1'b1, 32'hFFF00093, 8'd1, 1'b0);
    step(1'b1, 32'hFE112E23, 8'd2, 1'b0);
    step(1'b1, 32'h123452B7, 8'd3, 1'b0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h123452B7, 8'd3, 1'b1);
    step(1'b1, 32'h123452B7, 8'd3, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    step(1'b0, 32'h0, 8'h0, 1'b1);
    step(1'b1, 32'h001000EF, 8'd4, 1'b0);
    step(1'b1, 32'h00311093, 8'd5, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    chk("rstfull_out_valid", out_valid, 1'b0);
    chk("rstfull_in_ready", in_ready, 1'b1);
    chk("rstfull_out_imm", out_imm, 32'h0);
`ifdef IMM_GEN_FLUSH_EN
    step(1'b1, 32'h001000EF, 8'd6, 1'b0);
    step(1'b1, 32'h00311093, 8'd7, 1'b0);
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
`endif
    for (int k = 0; k < 400; k++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 7) != 0) inst[6:0] = opcs[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, inst, 8'($urandom), $urandom_range(0, 1) == 1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 8'h0, 1'b1);
    chk("drain_out_valid", out_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
